sdp_ram_rd_if: RTL and testbench
================================

# sdp_ram_rd_if

AXI4-slave read interface onto the read port of a simple-dual-port RAM; the read-side counterpart of the RAM write interface used in the same RAM block. It accepts one AR burst at a time and issues one RAM read per beat, accounting for a fixed RAM read latency. Returned words pass through a small credit-protected FIFO so RREADY backpressure never loses data, and R-channel beats are returned with RLAST and RID.

## Interface
- DW, 512, data width in bits (RAM word = AXI beat)
- AW, 10, RAM word-address width
- RAM_LAT, 2, cycles from ram_re sampled to ram_rdata valid (>=1)
- FIFO_DEPTH, 4, return-buffer depth in words (power of 2, >= RAM_LAT+2)

- clk  in  1  clock; all logic on rising edge
- resetn  in  1  reset, synchronous, active-low
- ram_raddr  out  AW  RAM read address
- ram_re  out  1  RAM read enable, one word per cycle asserted
- ram_rdata  in  DW  RAM read data, valid RAM_LAT cycles after ram_re
- S_AXI_ARADDR  in  32  byte address; word index = ARADDR >> log2(DW/8)
- S_AXI_ARVALID  in  1  AR valid
- S_AXI_ARID  in  4  transaction ID, echoed on RID
- S_AXI_ARLEN  in  8  beats minus 1
- S_AXI_ARSIZE, ARBURST, ARLOCK, ARCACHE, ARQOS, ARPROT  in  3/2/1/4/4/3  ignored
- S_AXI_ARREADY  out  1  AR ready
- S_AXI_RDATA  out  DW  read data
- S_AXI_RVALID  out  1  read valid
- S_AXI_RRESP  out  2  constant 0 (OKAY)
- S_AXI_RLAST  out  1  final beat of burst
- S_AXI_RID  out  4  latched ARID
- S_AXI_RREADY  in  1  read ready

## Operation
- Bursts treated as INCR, full-width beats; ARBURST/ARSIZE not checked.
- FSM states: RESET, IDLE, ISSUE, DRAIN.
  - RESET: entered while resetn=0; next cycle -> IDLE with ARREADY=1.
  - IDLE: ARREADY=1. On AR handshake: latch word address, beats_left = ARLEN+1 (9-bit), RID; ARREADY<=0; -> ISSUE.
  - ISSUE: each cycle where credits allow (fifo_count + in_flight < FIFO_DEPTH), assert ram_re with current address, address+1, beats_left-1. Issuing the final beat -> DRAIN.
  - DRAIN: wait for R handshake with RLAST=1; then ARREADY<=1, -> IDLE.
- Address increments modulo 2^AW (wraps to 0 after all-ones; no error).
- Latency pipeline: RAM_LAT-deep shift register carrying {valid, last}; on exit, ram_rdata and last flag pushed into FIFO.
- in_flight = count of valid stages in the pipeline; credit check guarantees FIFO never overflows.
- FIFO is show-ahead: RVALID = not empty; RDATA/RLAST = head entry; pop on RVALID & RREADY. Push and pop in same cycle permitted, count unchanged.
- RRESP always 0.

## Timing
- Reset values: ARREADY=0, RVALID=0, RLAST=0, ram_re=0, FIFO and pipeline empty; ram_raddr, RDATA, RID don't-care.
- ARREADY rises the first cycle after resetn samples 1.
- AR handshake in cycle T: first ram_re in T+1; first RVALID in T+2+RAM_LAT.
- With RREADY held high and FIFO_DEPTH >= RAM_LAT+2: one beat per cycle, no bubbles; burst of N beats has RLAST in T+1+RAM_LAT+N.
- RREADY low: issue stalls once credits exhausted; RVALID/RDATA/RLAST held stable until handshake.
- Next AR accepted no earlier than the cycle after the RLAST handshake.
- Reset mid-burst: all state flushed in one cycle; no further R beats for the aborted burst.

## Test plan
- Single beat: ARADDR=0x40 (DW=512), ARLEN=0, ARID=3, RAM word1=0xA5.. -> ram_raddr=1, one beat RDATA=word1, RLAST=1, RID=3, RVALID at T+4 (RAM_LAT=2).
- 8-beat burst, RREADY=1, ARADDR=0 -> words 0..7 on consecutive cycles, RLAST only on 8th, ARREADY high the cycle after.
- Backpressure: 16-beat burst, RREADY toggled randomly and held low 10 cycles -> data in order, no loss/duplication, FIFO never exceeds 4, RDATA stable while RVALID&!RREADY.
- Wrap: word address 1022, ARLEN=3 -> ram_raddr 1022,1023,0,1.
- Max burst ARLEN=255 followed by back-to-back ARVALID -> 256 beats, second AR accepted only after RLAST, IDs correct.
- resetn low 1 cycle mid-burst (beat 3 of 8) -> RVALID=0 next cycle, ARREADY=1 the following cycle, fresh burst returns correct data.

Source files
------------

// File: rtl/sdp_ram_rd_if_if.sv
// AXI4 read-channel bundle (AR + R) between an AXI master and the RAM read slave.
// The slave modport is the view used by sdp_ram_rd_if.
interface sdp_ram_rd_if_if #(
    parameter int DW = 512
);
    logic [31:0]   ARADDR;
    logic          ARVALID;
    logic [3:0]    ARID;
    logic [7:0]    ARLEN;
    logic [2:0]    ARSIZE;
    logic [1:0]    ARBURST;
    logic          ARLOCK;
    logic [3:0]    ARCACHE;
    logic [3:0]    ARQOS;
    logic [2:0]    ARPROT;
    logic          ARREADY;
    logic [DW-1:0] RDATA;
    logic          RVALID;
    logic [1:0]    RRESP;
    logic          RLAST;
    logic [3:0]    RID;
    logic          RREADY;

    modport slave (
        input  ARADDR, ARVALID, ARID, ARLEN, ARSIZE, ARBURST, ARLOCK,
               ARCACHE, ARQOS, ARPROT, RREADY,
        output ARREADY, RDATA, RVALID, RRESP, RLAST, RID
    );

    modport master (
        output ARADDR, ARVALID, ARID, ARLEN, ARSIZE, ARBURST, ARLOCK,
               ARCACHE, ARQOS, ARPROT, RREADY,
        input  ARREADY, RDATA, RVALID, RRESP, RLAST, RID
    );
endinterface

// File: rtl/sdp_ram_rd_if.sv
// AXI4 read slave onto a simple-dual-port RAM read port: one burst at a time, one RAM
// read per beat, fixed RAM latency absorbed by a credit-protected show-ahead return FIFO.
module sdp_ram_rd_if #(
    parameter int DW         = 512,
    parameter int AW         = 10,
    parameter int RAM_LAT    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          resetn,
    sdp_ram_rd_if_if.slave s_axi,
    output logic [AW-1:0] ram_raddr,
    output logic          ram_re,
    input  logic [DW-1:0] ram_rdata
);

    localparam int OFS = $clog2(DW / 8);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_IDLE  = 2'd1,
        S_ISSUE = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_arready;
    logic          w_arready_nxt;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] w_addr_nxt;
    logic [8:0]    r_beats;
    logic [8:0]    w_beats_nxt;
    logic [3:0]    r_rid;
    logic          r_re;
    logic          w_re_nxt;

    logic [RAM_LAT-1:0] r_pipe_v;
    logic [RAM_LAT-1:0] r_pipe_last;
    logic [CW-1:0]      r_in_flight;
    logic [CW-1:0]      w_in_flight_nxt;

    logic [DW-1:0]         r_mem_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_mem_last;
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nxt;

    logic w_ar_hs;
    logic w_issue_last;
    logic w_push;
    logic w_pop;
    logic w_rvalid;
    logic w_rlast_hs;
    logic w_unused;

    assign w_ar_hs      = (r_state == S_IDLE) & r_arready & s_axi.ARVALID;
    assign w_issue_last = r_re & (r_beats == 9'd1);
    assign w_push       = r_pipe_v[RAM_LAT-1];
    assign w_rvalid     = (r_cnt != {CW{1'b0}});
    assign w_pop        = w_rvalid & s_axi.RREADY;
    assign w_rlast_hs   = w_pop & r_mem_last[r_rptr];

    assign w_unused = &{1'b0, s_axi.ARSIZE, s_axi.ARBURST, s_axi.ARLOCK, s_axi.ARCACHE,
                        s_axi.ARQOS, s_axi.ARPROT, s_axi.ARADDR[31:OFS+AW],
                        s_axi.ARADDR[OFS-1:0]};

    // FSM state and ARREADY registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= S_RESET;
            r_arready <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_arready <= w_arready_nxt;
        end
    end

    // FSM next-state and next ARREADY
    always_comb begin
        w_state_nxt   = r_state;
        w_arready_nxt = r_arready;
        case (r_state)
            S_RESET: begin
                w_state_nxt   = S_IDLE;
                w_arready_nxt = 1'b1;
            end
            S_IDLE: begin
                if (w_ar_hs) begin
                    w_state_nxt   = S_ISSUE;
                    w_arready_nxt = 1'b0;
                end else begin
                    w_state_nxt   = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (w_issue_last) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_DRAIN: begin
                if (w_rlast_hs) begin
                    w_state_nxt   = S_IDLE;
                    w_arready_nxt = 1'b1;
                end else begin
                    w_state_nxt   = S_DRAIN;
                end
            end
            default: begin
                w_state_nxt   = S_RESET;
                w_arready_nxt = 1'b0;
            end
        endcase
    end

    // Next address, beat count, occupancy and RAM read enable.
    // ram_re is registered, so the credit check is made against next-cycle occupancy.
    always_comb begin
        w_addr_nxt  = r_addr;
        w_beats_nxt = r_beats;
        if (w_ar_hs) begin
            w_addr_nxt  = s_axi.ARADDR[OFS +: AW];
            w_beats_nxt = {1'b0, s_axi.ARLEN} + 9'd1;
        end else if (r_re) begin
            w_addr_nxt  = r_addr + {{(AW-1){1'b0}}, 1'b1};
            w_beats_nxt = r_beats - 9'd1;
        end else begin
            w_addr_nxt  = r_addr;
            w_beats_nxt = r_beats;
        end
        w_in_flight_nxt = r_in_flight + CW'(r_re) - CW'(w_push);
        w_cnt_nxt       = r_cnt + CW'(w_push) - CW'(w_pop);
        w_re_nxt        = (w_state_nxt == S_ISSUE) && (w_beats_nxt != 9'd0) &&
                          (({1'b0, w_cnt_nxt} + {1'b0, w_in_flight_nxt}) < DEPTH_C);
    end

    // Burst address/count/ID and read-enable registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_addr      <= {AW{1'b0}};
            r_beats     <= 9'd0;
            r_rid       <= 4'd0;
            r_re        <= 1'b0;
            r_in_flight <= {CW{1'b0}};
        end else begin
            r_addr      <= w_addr_nxt;
            r_beats     <= w_beats_nxt;
            r_re        <= w_re_nxt;
            r_in_flight <= w_in_flight_nxt;
            if (w_ar_hs) begin
                r_rid <= s_axi.ARID;
            end else begin
                r_rid <= r_rid;
            end
        end
    end

    // RAM latency shadow pipeline carrying {valid, last}
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pipe_v    <= {RAM_LAT{1'b0}};
            r_pipe_last <= {RAM_LAT{1'b0}};
        end else begin
            r_pipe_v[0]    <= r_re;
            r_pipe_last[0] <= w_issue_last;
            for (int i = 1; i < RAM_LAT; i++) begin
                r_pipe_v[i]    <= r_pipe_v[i-1];
                r_pipe_last[i] <= r_pipe_last[i-1];
            end
        end
    end

    // Return FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wptr <= {PW{1'b0}};
            r_rptr <= {PW{1'b0}};
            r_cnt  <= {CW{1'b0}};
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_push) begin
                r_wptr <= r_wptr + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                r_wptr <= r_wptr;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                r_rptr <= r_rptr;
            end
        end
    end

    // Return FIFO storage; contents are qualified by occupancy, so no reset needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wptr] <= ram_rdata;
            r_mem_last[r_wptr] <= r_pipe_last[RAM_LAT-1];
        end
    end

    assign ram_raddr     = r_addr;
    assign ram_re        = r_re;
    assign s_axi.ARREADY = r_arready;
    assign s_axi.RVALID  = w_rvalid;
    assign s_axi.RDATA   = r_mem_data[r_rptr];
    assign s_axi.RLAST   = w_rvalid & r_mem_last[r_rptr];
    assign s_axi.RID     = r_rid;
    assign s_axi.RRESP   = 2'b00;

endmodule

// File: tb/tb_sdp_ram_rd_if.sv
// Directed bench for sdp_ram_rd_if: RAM model with 2-cycle read latency and
// per-scenario tasks checking AXI read behaviour against hand-derived values.
module tb_sdp_ram_rd_if;
    localparam int DW = 512;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          resetn;
    logic [AW-1:0] ram_raddr;
    logic          ram_re;
    logic [DW-1:0] ram_rdata;
    logic [AW-1:0] p0;
    logic [AW-1:0] p1;
    logic [AW-1:0] iss_q [$];
    int total = 0;
    int bad   = 0;

    sdp_ram_rd_if_if #(.DW(DW)) axi ();

    sdp_ram_rd_if #(.DW(DW), .AW(AW), .RAM_LAT(2), .FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .s_axi    (axi.slave),
        .ram_raddr(ram_raddr),
        .ram_re   (ram_re),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] wd(input logic [AW-1:0] a);
        logic [31:0] w;
        w  = {22'h0A5A5A, a};
        wd = {16{w}};
    endfunction

    // RAM model: address registered twice, data valid two cycles after ram_re
    always @(posedge clk) begin
        p0 <= ram_raddr;
        p1 <= p0;
        if (resetn && ram_re) iss_q.push_back(ram_raddr);
    end
    assign ram_rdata = wd(p1);

    task automatic send_ar(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id);
        int n = 0;
        axi.ARADDR  = a;
        axi.ARLEN   = l;
        axi.ARID    = id;
        axi.ARVALID = 1'b1;
        while (axi.ARREADY !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 50) begin
            bad++;
            $display("FAIL ar_timeout: waited %0d cycles, required < 50", n);
        end
        @(negedge clk);
        axi.ARVALID = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        total += 4;
        if (axi.ARREADY !== 1'b0) begin bad++; $display("FAIL rst_arready: got %b exp 0", axi.ARREADY); end
        if (axi.RVALID !== 1'b0) begin bad++; $display("FAIL rst_rvalid: got %b exp 0", axi.RVALID); end
        if (axi.RLAST !== 1'b0) begin bad++; $display("FAIL rst_rlast: got %b exp 0", axi.RLAST); end
        if (ram_re !== 1'b0) begin bad++; $display("FAIL rst_ram_re: got %b exp 0", ram_re); end
        resetn = 1'b1;
        @(negedge clk);
        total++;
        if (axi.ARREADY !== 1'b1) begin bad++; $display("FAIL rst_arready_rise: got %b exp 1", axi.ARREADY); end
    endtask

    task automatic test_single();
        axi.RREADY = 1'b1;
        send_ar(32'h0000_0040, 8'd0, 4'd3);
        total += 2;
        if (ram_re !== 1'b1) begin bad++; $display("FAIL single_re: got %b exp 1", ram_re); end
        if (ram_raddr !== 10'd1) begin bad++; $display("FAIL single_raddr: got %0d exp 1", ram_raddr); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++;
            if (axi.RVALID !== 1'b0) begin bad++; $display("FAIL single_early_rvalid: cycle %0d got %b exp 0", k + 2, axi.RVALID); end
        end
        @(negedge clk);
        total += 5;
        if (axi.RVALID !== 1'b1) begin bad++; $display("FAIL single_rvalid: got %b exp 1", axi.RVALID); end
        if (axi.RDATA !== wd(10'd1)) begin bad++; $display("FAIL single_rdata: got %h exp %h", axi.RDATA, wd(10'd1)); end
        if (axi.RLAST !== 1'b1) begin bad++; $display("FAIL single_rlast: got %b exp 1", axi.RLAST); end
        if (axi.RID !== 4'd3) begin bad++; $display("FAIL single_rid: got %0d exp 3", axi.RID); end
        if (axi.RRESP !== 2'b00) begin bad++; $display("FAIL single_rresp: got %0d exp 0", axi.RRESP); end
        @(negedge clk);
        total += 2;
        if (axi.RVALID !== 1'b0) begin bad++; $display("FAIL single_after_rvalid: got %b exp 0", axi.RVALID); end
        if (axi.ARREADY !== 1'b1) begin bad++; $display("FAIL single_arready: got %b exp 1", axi.ARREADY); end
    endtask

    task automatic test_burst8();
        axi.RREADY = 1'b1;
        send_ar(32'h0000_0000, 8'd7, 4'd5);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            total += 4;
            if (axi.RVALID !== 1'b1) begin bad++; $display("FAIL b8_rvalid: beat %0d got %b exp 1", k, axi.RVALID); end
            if (axi.RDATA !== wd(10'(k))) begin bad++; $display("FAIL b8_rdata: beat %0d got %h exp %h", k, axi.RDATA, wd(10'(k))); end
            if (axi.RLAST !== (k == 7)) begin bad++; $display("FAIL b8_rlast: beat %0d got %b exp %b", k, axi.RLAST, (k == 7)); end
            if (axi.ARREADY !== 1'b0) begin bad++; $display("FAIL b8_arready_busy: beat %0d got %b exp 0", k, axi.ARREADY); end
            @(negedge clk);
        end
        total += 2;
        if (axi.ARREADY !== 1'b1) begin bad++; $display("FAIL b8_arready: got %b exp 1", axi.ARREADY); end
        if (axi.RVALID !== 1'b0) begin bad++; $display("FAIL b8_tail_rvalid: got %b exp 0", axi.RVALID); end
    endtask

    task automatic test_backpressure();
        logic [31:0]   pat = 32'hB5C3_6A9D;
        int            idx = 0;
        int            cyc = 0;
        logic          hold = 1'b0;
        logic [DW-1:0] hd;
        logic          hl;
        logic          rr;
        axi.RREADY = 1'b0;
        send_ar(32'(100 * 64), 8'd15, 4'd6);
        while (idx < 16 && cyc < 300) begin
            if (hold) begin
                total++;
                if (axi.RVALID !== 1'b1 || axi.RDATA !== hd || axi.RLAST !== hl) begin
                    bad++;
                    $display("FAIL bp_stable: cycle %0d got v=%b last=%b data=%h exp v=1 last=%b data=%h",
                             cyc, axi.RVALID, axi.RLAST, axi.RDATA, hl, hd);
                end
            end
            total++;
            if (dut.r_cnt > 3'd4) begin bad++; $display("FAIL bp_fifo_level: got %0d exp <= 4", dut.r_cnt); end
            if (cyc == 9) begin
                total++;
                if (ram_re !== 1'b0) begin bad++; $display("FAIL bp_stall: got %b exp 0", ram_re); end
            end
            rr = (cyc < 10) ? 1'b0 : ((cyc < 42) ? pat[cyc - 10] : 1'b1);
            axi.RREADY = rr;
            if (axi.RVALID === 1'b1) begin
                if (rr) begin
                    total += 2;
                    if (axi.RDATA !== wd(10'(100 + idx))) begin bad++; $display("FAIL bp_rdata: beat %0d got %h exp %h", idx, axi.RDATA, wd(10'(100 + idx))); end
                    if (axi.RLAST !== (idx == 15)) begin bad++; $display("FAIL bp_rlast: beat %0d got %b exp %b", idx, axi.RLAST, (idx == 15)); end
                    idx++;
                    hold = 1'b0;
                end else begin
                    hold = 1'b1;
                    hd   = axi.RDATA;
                    hl   = axi.RLAST;
                end
            end else begin
                hold = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        total += 2;
        if (idx != 16) begin bad++; $display("FAIL bp_count: got %0d beats exp 16", idx); end
        if (axi.RVALID !== 1'b0) begin bad++; $display("FAIL bp_extra_beat: got %b exp 0", axi.RVALID); end
        axi.RREADY = 1'b1;
    endtask

    task automatic test_wrap();
        logic [AW-1:0] ea;
        int            k = 0;
        int            cyc = 0;
        axi.RREADY = 1'b1;
        iss_q.delete();
        send_ar(32'h0000_FF80, 8'd3, 4'd2);
        while (k < 4 && cyc < 30) begin
            if (axi.RVALID === 1'b1) begin
                ea = 10'd1022 + 10'(k);
                total++;
                if (axi.RDATA !== wd(ea)) begin bad++; $display("FAIL wrap_rdata: beat %0d got %h exp %h", k, axi.RDATA, wd(ea)); end
                k++;
            end
            cyc++;
            @(negedge clk);
        end
        total++;
        if (iss_q.size() != 4) begin
            bad++;
            $display("FAIL wrap_issue_count: got %0d exp 4", iss_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                ea = 10'd1022 + 10'(i);
                total++;
                if (iss_q[i] !== ea) begin bad++; $display("FAIL wrap_raddr: issue %0d got %0d exp %0d", i, iss_q[i], ea); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int beat = 0;
        int cyc = 0;
        axi.RREADY = 1'b1;
        send_ar(32'h0000_0000, 8'd255, 4'd9);
        axi.ARADDR  = 32'(500 * 64);
        axi.ARLEN   = 8'd1;
        axi.ARID    = 4'd12;
        axi.ARVALID = 1'b1;
        while (beat < 256 && cyc < 400) begin
            total++;
            if (axi.ARREADY !== 1'b0) begin bad++; $display("FAIL b2b_early_arready: beat %0d got %b exp 0", beat, axi.ARREADY); end
            if (axi.RVALID === 1'b1) begin
                total += 3;
                if (axi.RID !== 4'd9) begin bad++; $display("FAIL b2b_rid1: beat %0d got %0d exp 9", beat, axi.RID); end
                if (axi.RDATA !== wd(10'(beat))) begin bad++; $display("FAIL b2b_rdata1: beat %0d got %h exp %h", beat, axi.RDATA, wd(10'(beat))); end
                if (axi.RLAST !== (beat == 255)) begin bad++; $display("FAIL b2b_rlast1: beat %0d got %b exp %b", beat, axi.RLAST, (beat == 255)); end
                beat++;
            end
            cyc++;
            @(negedge clk);
        end
        total += 2;
        if (cyc != 259) begin bad++; $display("FAIL b2b_cycles: got %0d exp 259", cyc); end
        if (axi.ARREADY !== 1'b1) begin bad++; $display("FAIL b2b_arready: got %b exp 1", axi.ARREADY); end
        @(negedge clk);
        axi.ARVALID = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            total += 4;
            if (axi.RVALID !== 1'b1) begin bad++; $display("FAIL b2b_rvalid2: beat %0d got %b exp 1", k, axi.RVALID); end
            if (axi.RID !== 4'd12) begin bad++; $display("FAIL b2b_rid2: beat %0d got %0d exp 12", k, axi.RID); end
            if (axi.RDATA !== wd(10'(500 + k))) begin bad++; $display("FAIL b2b_rdata2: beat %0d got %h exp %h", k, axi.RDATA, wd(10'(500 + k))); end
            if (axi.RLAST !== (k == 1)) begin bad++; $display("FAIL b2b_rlast2: beat %0d got %b exp %b", k, axi.RLAST, (k == 1)); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        axi.RREADY = 1'b1;
        send_ar(32'(200 * 64), 8'd7, 4'd4);
        repeat (5) @(negedge clk);
        total++;
        if (axi.RDATA !== wd(10'd202)) begin bad++; $display("FAIL rm_beat3: got %h exp %h", axi.RDATA, wd(10'd202)); end
        resetn = 1'b0;
        @(negedge clk);
        total += 2;
        if (axi.RVALID !== 1'b0) begin bad++; $display("FAIL rm_rvalid: got %b exp 0", axi.RVALID); end
        if (axi.ARREADY !== 1'b0) begin bad++; $display("FAIL rm_arready_low: got %b exp 0", axi.ARREADY); end
        resetn = 1'b1;
        @(negedge clk);
        total++;
        if (axi.ARREADY !== 1'b1) begin bad++; $display("FAIL rm_arready: got %b exp 1", axi.ARREADY); end
        for (int k = 0; k < 6; k++) begin
            total++;
            if (axi.RVALID !== 1'b0) begin bad++; $display("FAIL rm_stale_beat: cycle %0d got %b exp 0", k, axi.RVALID); end
            @(negedge clk);
        end
        send_ar(32'(300 * 64), 8'd1, 4'd7);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            total += 4;
            if (axi.RVALID !== 1'b1) begin bad++; $display("FAIL rm_new_rvalid: beat %0d got %b exp 1", k, axi.RVALID); end
            if (axi.RDATA !== wd(10'(300 + k))) begin bad++; $display("FAIL rm_new_rdata: beat %0d got %h exp %h", k, axi.RDATA, wd(10'(300 + k))); end
            if (axi.RID !== 4'd7) begin bad++; $display("FAIL rm_new_rid: beat %0d got %0d exp 7", k, axi.RID); end
            if (axi.RLAST !== (k == 1)) begin bad++; $display("FAIL rm_new_rlast: beat %0d got %b exp %b", k, axi.RLAST, (k == 1)); end
            @(negedge clk);
        end
    endtask

    initial begin
        resetn      = 1'b0;
        axi.ARADDR  = 32'd0;
        axi.ARVALID = 1'b0;
        axi.ARID    = 4'd0;
        axi.ARLEN   = 8'd0;
        axi.ARSIZE  = 3'd6;
        axi.ARBURST = 2'd1;
        axi.ARLOCK  = 1'b0;
        axi.ARCACHE = 4'd0;
        axi.ARQOS   = 4'd0;
        axi.ARPROT  = 3'd0;
        axi.RREADY  = 1'b0;
        test_reset();
        test_single();
        test_burst8();
        test_backpressure();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
